dma_ctrl: RTL and testbench
===========================

Name: dma_ctrl

Overview:
- Single-channel block-copy DMA engine that moves a fixed-length block of words between an internal data memory (IO port) and an external memory (EP port).
- Both memories read asynchronously and write on the rising clk edge.
- One wrb line sets direction for both memories: internal memory write-enable = wrb, external memory write-enable = ~wrb.
- The transfer starts on its own after reset, moves one word per unstalled cycle and stops after COUNT words.

Parameters:
- ADDR_W, 16, width of IOA and EPA.
- DATA_W, 16, width of all data buses.
- INT_BASE, 16'h0000, first internal address.
- EXT_BASE, 16'h0000, first external address.
- COUNT, 16, words per block; legal range 1..2^ADDR_W.
- DIR, 1'b1, initial direction. 1 = external→internal (wrb=1); 0 = internal→external (wrb=0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IOA  out  ADDR_W  internal memory address.
- IOD_IN  in  DATA_W  internal memory read data.
- IOD_OUT  out  DATA_W  write data to internal memory.
- EPA  out  ADDR_W  external memory address.
- EPD_IN  in  DATA_W  external memory read data.
- EPD_OUT  out  DATA_W  write data to external memory.
- wrb  out  1  direction/write strobe. 1: internal written, external read. 0: external written, internal read.
- stall_int  in  1  internal side busy; freeze transfer.
- stall_ext  in  1  external side busy; freeze transfer.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, idx=0, wrb=DIR.
  - IOA=INT_BASE, EPA=EXT_BASE.
- States are IDLE, XFER and DONE.
- IDLE→XFER on the first rising edge after rst releases. IDLE lasts exactly one cycle.
- Addressing:
  - IOA = INT_BASE+idx and EPA = EXT_BASE+idx, both modulo 2^ADDR_W (wrap-around allowed).
  - Address outputs are registered from idx.
- Data path is combinational:
  - IOD_OUT = EPD_IN when wrb=1, else 0.
  - EPD_OUT = IOD_IN when wrb=0, else 0.
  - Each word therefore completes in the cycle its address is presented; the destination memory captures it at the next rising edge.
- XFER, stall = stall_int | stall_ext:
  - stall=1: idx, addresses and wrb hold. The destination rewrites the same word with the same data, which is harmless.
  - stall=0: idx increments.
  - stall=0 and idx==COUNT-1: idx holds and the next state is DONE.
- Stall timing: stall is sampled at the rising edge; a stall asserted mid-cycle takes effect at the next edge. Stalls of any length, including back-to-back stalls, are legal.
- DONE is terminal until reset:
  - Addresses hold the last word; wrb holds.
  - The last word is rewritten idempotently.
- Reset mid-transfer: immediate return to reset values; the block restarts from word 0 after release.
- COUNT=1: XFER lasts one unstalled cycle.

Optional Feature:
- Macro: DMAC_PINGPONG_EN.
- Defined:
  - The first entry to DONE instead goes to a second XFER pass with wrb inverted and idx=0, over the same base addresses, so the block is copied back.
  - DONE follows the second pass.
  - Stall rules are unchanged.
- Undefined: single pass only, as described above.

Decomposition:
- Package dmac_pkg:
  - state enum {IDLE, XFER, DONE}.
  - Default ADDR_W and DATA_W localparams.
  - DIR_EXT2INT=1 and DIR_INT2EXT=0 constants.
- Sub-module dmac_addr_gen holds the index counter, stall gating, terminal-count detection and base+idx adders.
- The top level holds the FSM, wrb and the data muxes.

Test Plan:
- Reset, then a defaults run with no stall.
  - Expected: IOA/EPA step 0,1,…,15 on consecutive cycles with wrb=1.
  - Internal mem[i] == external mem[i] for i=0..15, and DONE from cycle 17.
- stall_int asserted for 3 cycles at idx=3.
  - Expected: IOA/EPA hold at 3 for 3 cycles, then resume at 4.
  - Total transfer is 19 cycles and the data are correct.
- stall_ext and stall_int overlapped, then two separate stalls (3 cycles each, 4 cycles apart).
  - Expected: stall is the OR of both, no word is skipped or duplicated, and the final contents are correct.
- DIR=0, INT_BASE=16'h0010, EXT_BASE=16'hFFFE, COUNT=4.
  - Expected: EPA wraps FFFE, FFFF, 0000, 0001 with wrb=0; external memory receives internal words 10..13.
- rst pulled low at idx=7 for 1 ns.
  - Expected: outputs are asynchronously at reset values, and the restart rewrites from word 0.
- DMAC_PINGPONG_EN defined, COUNT=4.
  - Expected: pass 1 runs with wrb=1, then pass 2 with wrb=0 over addresses 0..3, then DONE.
  - Both memories hold identical data.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared definitions for the dma_ctrl block-copy engine.
//   dmac_state_e : controller states (IDLE -> XFER -> DONE)
//   DMAC_ADDR_W  : default address width
//   DMAC_DATA_W  : default data width
//   DIR_EXT2INT  : wrb value for external -> internal copies
//   DIR_INT2EXT  : wrb value for internal -> external copies
`timescale 1ns/1ps
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } dmac_state_e;

  localparam int DMAC_ADDR_W = 16;
  localparam int DMAC_DATA_W = 16;

  localparam logic DIR_EXT2INT = 1'b1;
  localparam logic DIR_INT2EXT = 1'b0;

endpackage

// File: rtl/dma_ctrl_if.sv
// Memory-side bus of the dma_ctrl engine.
//   IOA / IOD_IN / IOD_OUT : internal memory address, read data, write data
//   EPA / EPD_IN / EPD_OUT : external memory address, read data, write data
//   wrb                    : 1 = internal memory written, external read;
//                            0 = external memory written, internal read
//   stall_int / stall_ext  : busy indications from either memory side
// Flow control: there is no valid/ready pair. The engine presents one word
// per cycle (address + write data); a word is accepted by the edge that
// ends the cycle unless stall_int | stall_ext is high at that edge, in which
// case the same word is presented again in the next cycle. Rewriting a word
// with identical data is harmless, so the destination may capture it on
// every edge.
// Modports: master = engine side, slave = memory side.
`timescale 1ns/1ps
interface dma_ctrl_if
  import dmac_pkg::*;
#(
  parameter int ADDR_W = DMAC_ADDR_W,
  parameter int DATA_W = DMAC_DATA_W
) ();

  logic [ADDR_W-1:0] IOA;
  logic [DATA_W-1:0] IOD_IN;
  logic [DATA_W-1:0] IOD_OUT;
  logic [ADDR_W-1:0] EPA;
  logic [DATA_W-1:0] EPD_IN;
  logic [DATA_W-1:0] EPD_OUT;
  logic              wrb;
  logic              stall_int;
  logic              stall_ext;

  modport master (
    output IOA, IOD_OUT, EPA, EPD_OUT, wrb,
    input  IOD_IN, EPD_IN, stall_int, stall_ext
  );

  modport slave (
    input  IOA, IOD_OUT, EPA, EPD_OUT, wrb,
    output IOD_IN, EPD_IN, stall_int, stall_ext
  );

endinterface

// File: rtl/dmac_addr_gen.sv
// Word index counter and address generator for dma_ctrl.
//   clk, rst : clock, asynchronous active-low reset
//   en       : counting allowed (controller in XFER)
//   stall    : combined stall; freezes the index
//   clr      : restart the index at word 0 (start of a second pass)
//   last     : current index is the final word of the block
//   ioa, epa : registered INT_BASE+idx / EXT_BASE+idx, modulo 2^ADDR_W
`timescale 1ns/1ps
module dmac_addr_gen
  import dmac_pkg::*;
#(
  parameter int                ADDR_W   = DMAC_ADDR_W,
  parameter logic [ADDR_W-1:0] INT_BASE = '0,
  parameter logic [ADDR_W-1:0] EXT_BASE = '0,
  parameter int                COUNT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              clr,
  output logic              last,
  output logic [ADDR_W-1:0] ioa,
  output logic [ADDR_W-1:0] epa
);

  // COUNT may be 2^ADDR_W, so the final index always fits in ADDR_W bits.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COUNT - 1);

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;

  assign last = (idx == LAST_IDX);

  // The index parks on the last word; the controller leaves XFER on the
  // same edge, so the last word stays presented afterwards.
  always_comb begin
    idx_nxt = idx;
    if (clr) begin
      idx_nxt = '0;
    end else if (en && !stall && !last) begin
      idx_nxt = idx + ADDR_W'(1);
    end
  end

  // Addresses are registered from the next index so they always equal
  // base+idx; the adders wrap naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      ioa <= INT_BASE;
      epa <= EXT_BASE;
    end else begin
      idx <= idx_nxt;
      ioa <= INT_BASE + idx_nxt;
      epa <= EXT_BASE + idx_nxt;
    end
  end

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel block-copy DMA engine.
// Moves COUNT words between an internal memory (IO side) and an external
// memory (EP side), one word per unstalled cycle, starting by itself one
// cycle after reset release and stopping in DONE until the next reset.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : dma_ctrl_if.master (addresses, data, wrb, stalls)
//   dbg_state : current controller state
// Optional build macro DMAC_PINGPONG_EN: after the first pass the block is
// copied back in a second pass with wrb inverted, then DONE.
`timescale 1ns/1ps
module dma_ctrl
  import dmac_pkg::*;
#(
  parameter int                ADDR_W   = DMAC_ADDR_W,
  parameter int                DATA_W   = DMAC_DATA_W,
  parameter logic [ADDR_W-1:0] INT_BASE = '0,
  parameter logic [ADDR_W-1:0] EXT_BASE = '0,
  parameter int                COUNT    = 16,
  parameter logic              DIR      = DIR_EXT2INT
) (
  input  logic         clk,
  input  logic         rst,
  dma_ctrl_if.master   bus,
  output dmac_state_e  dbg_state
);

  dmac_state_e       state;
  logic              wrb_q;
  logic              stall;
  logic              last;
  logic              clr;
  logic [ADDR_W-1:0] ioa;
  logic [ADDR_W-1:0] epa;
  logic [DATA_W-1:0] iod_out;
  logic [DATA_W-1:0] epd_out;

  assign stall = bus.stall_int | bus.stall_ext;

`ifdef DMAC_PINGPONG_EN
  logic second_pass;
  // End of the first pass restarts the index for the copy-back pass.
  assign clr = (state == XFER) && !stall && last && !second_pass;
`else
  assign clr = 1'b0;
`endif

  dmac_addr_gen #(
    .ADDR_W   (ADDR_W),
    .INT_BASE (INT_BASE),
    .EXT_BASE (EXT_BASE),
    .COUNT    (COUNT)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (state == XFER),
    .stall (stall),
    .clr   (clr),
    .last  (last),
    .ioa   (ioa),
    .epa   (epa)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wrb_q <= DIR;
`ifdef DMAC_PINGPONG_EN
      second_pass <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= XFER;
        XFER: begin
          if (!stall && last) begin
`ifdef DMAC_PINGPONG_EN
            if (!second_pass) begin
              second_pass <= 1'b1;
              wrb_q       <= ~wrb_q;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational data path: the source word flows straight to the
  // destination, the idle direction is driven to zero.
  assign iod_out = (wrb_q == DIR_EXT2INT) ? bus.EPD_IN : '0;
  assign epd_out = (wrb_q == DIR_INT2EXT) ? bus.IOD_IN : '0;

  assign bus.IOA     = ioa;
  assign bus.EPA     = epa;
  assign bus.IOD_OUT = iod_out;
  assign bus.EPD_OUT = epd_out;
  assign bus.wrb     = wrb_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_dma_ctrl.sv
`timescale 1ns/1ps
module tb_dma_ctrl;
  import dmac_pkg::*;

  localparam int NI = 4;
`ifdef DMAC_PINGPONG_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int   sel = 0;
  logic st_int = 1'b0;
  logic st_ext = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // ---------------- instance configuration ----------------
  // 0: defaults; 1: int->ext with wrapping EPA; 2: COUNT=4; 3: COUNT=1
  function automatic int p_cnt(int s);
    case (s) 0: return 16; 1: return 4; 2: return 4; default: return 1; endcase
  endfunction
  function automatic logic [15:0] p_ib(int s);
    return (s == 1) ? 16'h0010 : 16'h0000;
  endfunction
  function automatic logic [15:0] p_eb(int s);
    return (s == 1) ? 16'hFFFE : 16'h0000;
  endfunction
  function automatic logic p_dir(int s);
    return (s == 1) ? 1'b0 : 1'b1;
  endfunction

  // ---------------- memories ----------------
  // A word not written since the current epoch reads as a seeded pattern,
  // so a new test gets fresh contents without touching the arrays.
  bit [15:0] imem [NI][65536];
  bit [7:0]  iep  [NI][65536];
  bit [15:0] emem [NI][65536];
  bit [7:0]  eep  [NI][65536];
  bit [7:0]  epoch = 8'd1;
  bit [15:0] seed_v = 16'h1234;

  function automatic logic [15:0] init_val(int s, bit ext, logic [15:0] a, logic [15:0] sd);
    return 16'(a * 16'h9E37) ^ sd ^ 16'(s * 4369) ^ (ext ? 16'hA5C3 : 16'h0000);
  endfunction

  function automatic logic [15:0] rd(int s, bit ext, logic [15:0] a);
    if (ext) return (eep[s][a] == epoch) ? emem[s][a] : init_val(s, 1'b1, a, seed_v);
    else     return (iep[s][a] == epoch) ? imem[s][a] : init_val(s, 1'b0, a, seed_v);
  endfunction

  dma_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  dma_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();
  dma_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_c ();
  dma_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_d ();
  dmac_state_e st_a, st_b, st_c, st_d;

  dma_ctrl dut_a (.clk(clk), .rst(rst), .bus(bus_a), .dbg_state(st_a));
  dma_ctrl #(.INT_BASE(16'h0010), .EXT_BASE(16'hFFFE), .COUNT(4), .DIR(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b), .dbg_state(st_b));
  dma_ctrl #(.COUNT(4)) dut_c (.clk(clk), .rst(rst), .bus(bus_c), .dbg_state(st_c));
  dma_ctrl #(.COUNT(1)) dut_d (.clk(clk), .rst(rst), .bus(bus_d), .dbg_state(st_d));

  assign bus_a.IOD_IN = rd(0, 1'b0, bus_a.IOA);
  assign bus_a.EPD_IN = rd(0, 1'b1, bus_a.EPA);
  assign bus_b.IOD_IN = rd(1, 1'b0, bus_b.IOA);
  assign bus_b.EPD_IN = rd(1, 1'b1, bus_b.EPA);
  assign bus_c.IOD_IN = rd(2, 1'b0, bus_c.IOA);
  assign bus_c.EPD_IN = rd(2, 1'b1, bus_c.EPA);
  assign bus_d.IOD_IN = rd(3, 1'b0, bus_d.IOA);
  assign bus_d.EPD_IN = rd(3, 1'b1, bus_d.EPA);

  assign bus_a.stall_int = (sel == 0) & st_int;
  assign bus_a.stall_ext = (sel == 0) & st_ext;
  assign bus_b.stall_int = (sel == 1) & st_int;
  assign bus_b.stall_ext = (sel == 1) & st_ext;
  assign bus_c.stall_int = (sel == 2) & st_int;
  assign bus_c.stall_ext = (sel == 2) & st_ext;
  assign bus_d.stall_int = (sel == 3) & st_int;
  assign bus_d.stall_ext = (sel == 3) & st_ext;

  always @(posedge clk) begin
    if (bus_a.wrb) begin imem[0][bus_a.IOA] <= bus_a.IOD_OUT; iep[0][bus_a.IOA] <= epoch; end
    else           begin emem[0][bus_a.EPA] <= bus_a.EPD_OUT; eep[0][bus_a.EPA] <= epoch; end
    if (bus_b.wrb) begin imem[1][bus_b.IOA] <= bus_b.IOD_OUT; iep[1][bus_b.IOA] <= epoch; end
    else           begin emem[1][bus_b.EPA] <= bus_b.EPD_OUT; eep[1][bus_b.EPA] <= epoch; end
    if (bus_c.wrb) begin imem[2][bus_c.IOA] <= bus_c.IOD_OUT; iep[2][bus_c.IOA] <= epoch; end
    else           begin emem[2][bus_c.EPA] <= bus_c.EPD_OUT; eep[2][bus_c.EPA] <= epoch; end
    if (bus_d.wrb) begin imem[3][bus_d.IOA] <= bus_d.IOD_OUT; iep[3][bus_d.IOA] <= epoch; end
    else           begin emem[3][bus_d.EPA] <= bus_d.EPD_OUT; eep[3][bus_d.EPA] <= epoch; end
  end

  // ---------------- observation of the selected instance ----------------
  logic [15:0] o_ioa, o_epa, o_iod, o_epd;
  logic        o_wrb;
  dmac_state_e o_state;
  always_comb begin
    case (sel)
      0: begin o_ioa = bus_a.IOA; o_epa = bus_a.EPA; o_iod = bus_a.IOD_OUT;
               o_epd = bus_a.EPD_OUT; o_wrb = bus_a.wrb; o_state = st_a; end
      1: begin o_ioa = bus_b.IOA; o_epa = bus_b.EPA; o_iod = bus_b.IOD_OUT;
               o_epd = bus_b.EPD_OUT; o_wrb = bus_b.wrb; o_state = st_b; end
      2: begin o_ioa = bus_c.IOA; o_epa = bus_c.EPA; o_iod = bus_c.IOD_OUT;
               o_epd = bus_c.EPD_OUT; o_wrb = bus_c.wrb; o_state = st_c; end
      default: begin o_ioa = bus_d.IOA; o_epa = bus_d.EPA; o_iod = bus_d.IOD_OUT;
               o_epd = bus_d.EPD_OUT; o_wrb = bus_d.wrb; o_state = st_d; end
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic new_epoch();
    epoch  = epoch + 8'd1;
    seed_v = 16'($urandom);
  endtask

  // Hold reset for a cycle, check the asynchronous reset values of
  // instance s, then release one ns after a rising edge.
  task automatic do_reset(input int s, input string name);
    sel = s; st_int = 1'b0; st_ext = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    new_epoch();
    #1;
    n_checks++;
    if (o_state !== IDLE || o_ioa !== p_ib(s) || o_epa !== p_eb(s) || o_wrb !== p_dir(s))
    begin
      n_fail++;
      $display("FAIL %s reset: got state=%0d ioa=%h epa=%h wrb=%b, expected state=%0d ioa=%h epa=%h wrb=%b",
               name, o_state, o_ioa, o_epa, o_wrb, IDLE, p_ib(s), p_eb(s), p_dir(s));
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Stall patterns indexed by transfer cycle k (k=0 is the first XFER cycle).
  function automatic logic [1:0] stall_pat(int mode, int k);
    logic si, se;
    si = 1'b0; se = 1'b0;
    case (mode)
      1: si = (k >= 3 && k <= 5);
      2: begin
        se = (k >= 2 && k <= 4) || (k >= 16 && k <= 18);
        si = (k >= 3 && k <= 6) || (k >= 9 && k <= 11);
      end
      3: begin
        si = ($urandom_range(0, 3) == 0);
        se = ($urandom_range(0, 3) == 0);
      end
      4: si = (k <= 1);
      default: ;
    endcase
    return {si, se};
  endfunction

  // Runs one block on instance s from its IDLE cycle. The reference is a
  // word counter: word w is presented until a cycle without stall, the
  // block ends after COUNT accepted words (per pass), then everything holds.
  task automatic run_block(input int s, input int mode, input int exp_cycles, input string name);
    int w, pass, k, done_k, cnt;
    bit done;
    logic wrb_e, si, se;
    logic [15:0] ib, eb, e_ioa, e_epa, src, e_iod, e_epd;
    dmac_state_e e_state;
    logic [1:0] sp;
    cnt = p_cnt(s); ib = p_ib(s); eb = p_eb(s);
    w = 0; pass = 0; k = 0; done_k = -1; done = 1'b0; wrb_e = p_dir(s);

    @(negedge clk);
    n_checks++;
    if (o_state !== IDLE || o_ioa !== ib || o_epa !== eb) begin
      n_fail++;
      $display("FAIL %s idle: got state=%0d ioa=%h epa=%h, expected state=%0d ioa=%h epa=%h",
               name, o_state, o_ioa, o_epa, IDLE, ib, eb);
    end

    while (k < 400 && !(done && k >= done_k + 3)) begin
      @(posedge clk); #1;
      sp = stall_pat(mode, k);
      si = sp[1]; se = sp[0];
      st_int = si; st_ext = se;
      @(negedge clk);
      e_state = done ? DONE : XFER;
      e_ioa   = ib + 16'(w);
      e_epa   = eb + 16'(w);
      // Every pass moves the original source contents.
      src     = p_dir(s) ? init_val(s, 1'b1, e_epa, seed_v) : init_val(s, 1'b0, e_ioa, seed_v);
      e_iod   = wrb_e ? src : 16'h0000;
      e_epd   = wrb_e ? 16'h0000 : src;
      n_checks++;
      if (o_state !== e_state || o_ioa !== e_ioa || o_epa !== e_epa || o_wrb !== wrb_e ||
          o_iod !== e_iod || o_epd !== e_epd) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got state=%0d ioa=%h epa=%h wrb=%b iod=%h epd=%h, expected state=%0d ioa=%h epa=%h wrb=%b iod=%h epd=%h",
                 name, k, o_state, o_ioa, o_epa, o_wrb, o_iod, o_epd,
                 e_state, e_ioa, e_epa, wrb_e, e_iod, e_epd);
      end
      if (!done && !(si | se)) begin
        if (w == cnt - 1) begin
          if (pass + 1 < PASSES) begin
            pass++; w = 0; wrb_e = ~wrb_e;
          end else begin
            done = 1'b1; done_k = k + 1;
          end
        end else begin
          w++;
        end
      end
      k++;
    end
    st_int = 1'b0; st_ext = 1'b0;

    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: transfer not finished after %0d cycles, required finish", name, k);
    end
    if (exp_cycles >= 0) begin
      n_checks++;
      if (done_k !== exp_cycles + (PASSES - 1) * cnt) begin
        n_fail++;
        $display("FAIL %s length: got %0d transfer cycles, expected %0d",
                 name, done_k, exp_cycles + (PASSES - 1) * cnt);
      end
    end

    // Memory contents: destination holds the source block, source intact,
    // and the word just past the block is untouched.
    for (int i = 0; i <= cnt; i++) begin
      logic [15:0] ia, ea, want_src, got_dst, got_src, want_out;
      ia = ib + 16'(i); ea = eb + 16'(i);
      if (p_dir(s)) begin
        want_src = init_val(s, 1'b1, ea, seed_v);
        got_dst  = rd(s, 1'b0, ia);
        got_src  = rd(s, 1'b1, ea);
        want_out = init_val(s, 1'b0, ia, seed_v);
      end else begin
        want_src = init_val(s, 1'b0, ia, seed_v);
        got_dst  = rd(s, 1'b1, ea);
        got_src  = rd(s, 1'b0, ia);
        want_out = init_val(s, 1'b1, ea, seed_v);
      end
      n_checks++;
      if (i < cnt) begin
        if (got_dst !== want_src || got_src !== want_src) begin
          n_fail++;
          $display("FAIL %s mem word %0d: got dst=%h src=%h, expected both %h",
                   name, i, got_dst, got_src, want_src);
        end
      end else if (got_dst !== want_out) begin
        n_fail++;
        $display("FAIL %s mem past end: got %h, expected untouched %h", name, got_dst, want_out);
      end
    end
  endtask

  // ---------------- test scenarios ----------------
  task automatic test_reset();
    do_reset(0, "reset_defaults");
    do_reset(1, "reset_wrap_cfg");
  endtask

  task automatic test_default_run();
    do_reset(0, "default_run");
    run_block(0, 0, 16, "default_run");
  endtask

  task automatic test_stall_int();
    do_reset(0, "stall_int");
    run_block(0, 1, 19, "stall_int");
  endtask

  task automatic test_stall_overlap();
    do_reset(0, "stall_overlap");
    run_block(0, 2, 27, "stall_overlap");
  endtask

  task automatic test_wrap();
    do_reset(1, "wrap");
    run_block(1, 0, 4, "wrap");
  endtask

  task automatic test_reset_mid();
    do_reset(0, "reset_mid");
    @(negedge clk);
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (o_ioa !== 16'h0007 || o_state !== XFER) begin
      n_fail++;
      $display("FAIL reset_mid before: got ioa=%h state=%0d, expected ioa=0007 state=%0d",
               o_ioa, o_state, XFER);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_ioa !== 16'h0000 || o_epa !== 16'h0000 || o_wrb !== 1'b1 || o_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid async: got ioa=%h epa=%h wrb=%b state=%0d, expected 0000 0000 1 %0d",
               o_ioa, o_epa, o_wrb, o_state, IDLE);
    end
    new_epoch();
    rst = 1'b1;
    run_block(0, 0, 16, "reset_mid_restart");
  endtask

  task automatic test_count4();
    do_reset(2, "count4");
    run_block(2, 0, 4, "count4");
  endtask

  task automatic test_count1();
    do_reset(3, "count1");
    run_block(3, 0, 1, "count1");
    do_reset(3, "count1_stall");
    run_block(3, 4, 3, "count1_stall");
  endtask

  task automatic test_random_stalls();
    for (int r = 0; r < 6; r++) begin
      int s;
      s = $urandom_range(0, NI - 1);
      do_reset(s, "random_stalls");
      run_block(s, 3, -1, "random_stalls");
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_stall_int();
    test_stall_overlap();
    test_wrap();
    test_reset_mid();
    test_count4();
    test_count1();
    test_random_stalls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
